// File: rtl/uart_program_loader.sv
// Serial boot loader: receives a length-prefixed 16-bit word image over 8N1 UART
// and writes it into BRAM port B while holding the CPU core stalled.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        start_load,
    output logic [15:0] addr_b,
    output logic [15:0] data_b,
    output logic        we_b,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        frame_err,
    output logic [15:0] word_count,
    output logic [1:0]  o_rx_state,
    output logic [2:0]  o_ld_state
);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] L_IDLE    = 3'd0;
    localparam logic [2:0] L_LEN_HI  = 3'd1;
    localparam logic [2:0] L_LEN_LO  = 3'd2;
    localparam logic [2:0] L_DATA_HI = 3'd3;
    localparam logic [2:0] L_DATA_LO = 3'd4;
    localparam logic [2:0] L_WRITE   = 3'd5;
    localparam logic [2:0] L_DONE    = 3'd6;
    localparam logic [2:0] L_ERR     = 3'd7;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] MAX_LEN   = 16'(MAX_WORDS);

    logic        r_rx_meta;
    logic        r_rx_sync;
    logic [1:0]  r_rx_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_byte_valid;
    logic        r_rx_ferr;

    logic [2:0]  r_ld_state;
    logic [15:0] r_len;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_we;
    logic        r_hold;
    logic        r_done;
    logic        r_ferr;
    logic [15:0] r_wcount;

    logic        w_start_ok;
    logic        w_busy;
    logic [15:0] w_len_next;
    logic [15:0] w_wcount_next;

    // Idle-high reset value keeps the receiver from seeing a false start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= R_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_state <= R_START;
                        r_clk_cnt  <= '0;
                        r_bit_idx  <= '0;
                    end
                end
                R_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= r_rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                R_DATA: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= R_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                R_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= R_IDLE;
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    assign w_start_ok    = start_load && ((r_ld_state == L_IDLE) || (r_ld_state == L_DONE) ||
                                          (r_ld_state == L_ERR));
    assign w_busy        = (r_ld_state != L_IDLE) && (r_ld_state != L_DONE) && (r_ld_state != L_ERR);
    assign w_len_next    = {r_len[15:8], r_shift};
    assign w_wcount_next = r_wcount + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_state <= L_IDLE;
            r_len      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_wcount   <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_ld_state <= L_LEN_HI;
                r_hold     <= 1'b1;
                r_wcount   <= '0;
                r_addr     <= '0;
                r_ferr     <= 1'b0;
            end else if (w_busy && r_rx_ferr) begin
                // A word already being written still counts before we give up.
                if (r_ld_state == L_WRITE) begin
                    r_wcount <= w_wcount_next;
                end
                r_ld_state <= L_ERR;
                r_ferr     <= 1'b1;
            end else begin
                case (r_ld_state)
                    L_LEN_HI: begin
                        if (r_byte_valid) begin
                            r_len[15:8] <= r_shift;
                            r_ld_state  <= L_LEN_LO;
                        end
                    end
                    L_LEN_LO: begin
                        if (r_byte_valid) begin
                            r_len <= w_len_next;
                            if (w_len_next == 16'd0) begin
                                r_ld_state <= L_DONE;
                                r_done     <= 1'b1;
                                r_hold     <= 1'b0;
                            end else if (w_len_next > MAX_LEN) begin
                                r_ld_state <= L_ERR;
                                r_ferr     <= 1'b1;
                            end else begin
                                r_ld_state <= L_DATA_HI;
                            end
                        end
                    end
                    L_DATA_HI: begin
                        if (r_byte_valid) begin
                            r_data[15:8] <= r_shift;
                            r_ld_state   <= L_DATA_LO;
                        end
                    end
                    L_DATA_LO: begin
                        if (r_byte_valid) begin
                            r_data[7:0] <= r_shift;
                            r_addr      <= r_wcount;
                            r_we        <= 1'b1;
                            r_ld_state  <= L_WRITE;
                        end
                    end
                    L_WRITE: begin
                        r_wcount <= w_wcount_next;
                        if (w_wcount_next == r_len) begin
                            r_ld_state <= L_DONE;
                            r_done     <= 1'b1;
                            r_hold     <= 1'b0;
                        end else begin
                            r_ld_state <= L_DATA_HI;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign addr_b     = r_addr;
    assign data_b     = r_data;
    assign we_b       = r_we;
    assign cpu_hold   = r_hold;
    assign load_done  = r_done;
    assign frame_err  = r_ferr;
    assign word_count = r_wcount;
    assign o_rx_state = r_rx_state;
    assign o_ld_state = r_ld_state;

endmodule
